// File: rtl/spell_execute_if.sv
// Operand/result bundle between the SPELL core and its execute stage.
// The core drives the instruction and stack operands; the execute stage returns registered results.
interface spell_execute_if;
  logic [7:0] opcode;
  logic [7:0] pc;
  logic [4:0] sp;
  logic [7:0] stack_top;
  logic [7:0] stack_belowtop;
  logic [7:0] memory_input;
  logic       out_of_order_exec;

  logic [7:0] next_pc;
  logic [4:0] next_sp;
  logic [1:0] stack_write_count;
  logic [7:0] set_stack_top;
  logic [7:0] set_stack_belowtop;
  logic [1:0] memory_write_type;
  logic [7:0] memory_write_addr;
  logic [7:0] memory_write_data;
  logic [7:0] delay_amount;
  logic       sleep;

  modport master (
    output opcode, pc, sp, stack_top, stack_belowtop, memory_input, out_of_order_exec,
    input  next_pc, next_sp, stack_write_count, set_stack_top, set_stack_belowtop,
    input  memory_write_type, memory_write_addr, memory_write_data, delay_amount, sleep
  );

  modport slave (
    input  opcode, pc, sp, stack_top, stack_belowtop, memory_input, out_of_order_exec,
    output next_pc, next_sp, stack_write_count, set_stack_top, set_stack_belowtop,
    output memory_write_type, memory_write_addr, memory_write_data, delay_amount, sleep
  );
endinterface

// File: rtl/spell_execute.sv
// SPELL execute stage: decodes one ASCII opcode and registers PC/SP/stack/memory/delay/sleep results.
// Optional feature: define SPELL_MUL_EN to make '*' a multiply instead of a literal push.
module spell_execute (
  input  logic          clk,
  input  logic          rst_n,
  spell_execute_if.slave exe
);

  localparam logic [7:0] OP_ADD   = 8'h2B; // '+'
  localparam logic [7:0] OP_SUB   = 8'h2D; // '-'
  localparam logic [7:0] OP_AND   = 8'h26; // '&'
  localparam logic [7:0] OP_OR    = 8'h7C; // '|'
  localparam logic [7:0] OP_XOR   = 8'h5E; // '^'
  localparam logic [7:0] OP_SHR   = 8'h3E; // '>'
  localparam logic [7:0] OP_SHL   = 8'h3C; // '<'
  localparam logic [7:0] OP_DUP   = 8'h32; // '2'
  localparam logic [7:0] OP_SWAP  = 8'h78; // 'x'
  localparam logic [7:0] OP_JUMP  = 8'h3D; // '='
  localparam logic [7:0] OP_LOOP  = 8'h40; // '@'
  localparam logic [7:0] OP_DRD   = 8'h3F; // '?'
  localparam logic [7:0] OP_IORD  = 8'h72; // 'r'
  localparam logic [7:0] OP_DWR   = 8'h21; // '!'
  localparam logic [7:0] OP_IOWR  = 8'h77; // 'w'
  localparam logic [7:0] OP_DELAY = 8'h2C; // ','
  localparam logic [7:0] OP_SLEEP = 8'h7A; // 'z'
`ifdef SPELL_MUL_EN
  localparam logic [7:0] OP_MUL   = 8'h2A; // '*'
`endif

  localparam logic [1:0] WR_NONE = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_IO   = 2'd2;

  logic [7:0] a_s;
  logic [7:0] b_s;
  logic [7:0] pc_step_s;

  logic [7:0] next_pc_s;
  logic [4:0] next_sp_s;
  logic [1:0] count_s;
  logic [7:0] top_s;
  logic [7:0] below_s;
  logic [1:0] wr_type_s;
  logic [7:0] wr_addr_s;
  logic [7:0] wr_data_s;
  logic [7:0] delay_s;
  logic       sleep_s;

  logic [7:0] next_pc_r;
  logic [4:0] next_sp_r;
  logic [1:0] count_r;
  logic [7:0] top_r;
  logic [7:0] below_r;
  logic [1:0] wr_type_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic [7:0] delay_r;
  logic       sleep_r;

  assign a_s = exe.stack_top;
  assign b_s = exe.stack_belowtop;

  // Injected instructions do not advance PC; only explicit jumps move it.
  always_comb begin
    if (exe.out_of_order_exec) begin
      pc_step_s = exe.pc;
    end else begin
      pc_step_s = exe.pc + 8'd1;
    end
  end

  // Opcode decode and result computation.
  always_comb begin
    next_pc_s = pc_step_s;
    next_sp_s = exe.sp;
    count_s   = 2'd0;
    top_s     = 8'd0;
    below_s   = 8'd0;
    wr_type_s = WR_NONE;
    wr_addr_s = 8'd0;
    wr_data_s = 8'd0;
    delay_s   = 8'd0;
    sleep_s   = 1'b0;

    case (exe.opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL: begin
        next_sp_s = exe.sp - 5'd1;
        count_s   = 2'd1;
        case (exe.opcode)
          OP_ADD:  top_s = b_s + a_s;
          OP_SUB:  top_s = b_s - a_s;
          OP_AND:  top_s = b_s & a_s;
          OP_OR:   top_s = b_s | a_s;
          OP_XOR:  top_s = b_s ^ a_s;
          // A shift count of 8 or more clears the value; the full 8-bit amount is honoured.
          OP_SHR:  top_s = b_s >> a_s;
          OP_SHL:  top_s = b_s << a_s;
          default: top_s = 8'd0;
        endcase
      end
`ifdef SPELL_MUL_EN
      OP_MUL: begin
        top_s     = 8'(b_s * a_s);
        next_sp_s = exe.sp - 5'd1;
        count_s   = 2'd1;
      end
`endif
      OP_DUP: begin
        top_s     = a_s;
        next_sp_s = exe.sp + 5'd1;
        count_s   = 2'd1;
      end
      OP_SWAP: begin
        top_s   = b_s;
        below_s = a_s;
        count_s = 2'd2;
      end
      OP_JUMP: begin
        next_pc_s = a_s;
        next_sp_s = exe.sp - 5'd1;
      end
      OP_LOOP: begin
        if (b_s != 8'd0) begin
          next_pc_s = a_s;
          next_sp_s = exe.sp - 5'd1;
          top_s     = b_s - 8'd1;
          count_s   = 2'd1;
        end else begin
          next_sp_s = exe.sp - 5'd2;
        end
      end
      OP_DRD, OP_IORD: begin
        top_s   = exe.memory_input;
        count_s = 2'd1;
      end
      OP_DWR, OP_IOWR: begin
        wr_type_s = (exe.opcode == OP_DWR) ? WR_DATA : WR_IO;
        wr_addr_s = a_s;
        wr_data_s = b_s;
        next_sp_s = exe.sp - 5'd2;
      end
      OP_DELAY: begin
        delay_s   = a_s;
        next_sp_s = exe.sp - 5'd1;
      end
      OP_SLEEP: begin
        sleep_s = 1'b1;
      end
      default: begin
        top_s     = exe.opcode;
        next_sp_s = exe.sp + 5'd1;
        count_s   = 2'd1;
      end
    endcase
  end

  // Result registers; cleared asynchronously while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_pc_r <= 8'd0;
      next_sp_r <= 5'd0;
      count_r   <= 2'd0;
      top_r     <= 8'd0;
      below_r   <= 8'd0;
      wr_type_r <= 2'd0;
      wr_addr_r <= 8'd0;
      wr_data_r <= 8'd0;
      delay_r   <= 8'd0;
      sleep_r   <= 1'b0;
    end else begin
      next_pc_r <= next_pc_s;
      next_sp_r <= next_sp_s;
      count_r   <= count_s;
      top_r     <= top_s;
      below_r   <= below_s;
      wr_type_r <= wr_type_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      delay_r   <= delay_s;
      sleep_r   <= sleep_s;
    end
  end

  assign exe.next_pc            = next_pc_r;
  assign exe.next_sp            = next_sp_r;
  assign exe.stack_write_count  = count_r;
  assign exe.set_stack_top      = top_r;
  assign exe.set_stack_belowtop = below_r;
  assign exe.memory_write_type  = wr_type_r;
  assign exe.memory_write_addr  = wr_addr_r;
  assign exe.memory_write_data  = wr_data_r;
  assign exe.delay_amount       = delay_r;
  assign exe.sleep              = sleep_r;

endmodule

// File: tb/tb_spell_execute.sv
// Self-checking bench for spell_execute: directed cases plus randomized opcodes against a reference model.
module tb_spell_execute;

  logic clk;
  logic rst_n;
  int   checks_r;
  int   failures_r;

  spell_execute_if exe ();

  spell_execute dut (
    .clk   (clk),
    .rst_n (rst_n),
    .exe   (exe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int sp;
    int cnt;
    int top;
    int below;
    int wtype;
    int waddr;
    int wdata;
    int dly;
    int slp;
  } exp_t;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks_r++;
    if (obs != exp) begin
      failures_r++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  function automatic exp_t ref_model(input int op, input int pc, input int sp, input int a,
                                     input int b, input int mem, input bit ooo);
    exp_t e;
    e.pc = ooo ? pc : (pc + 1) % 256;
    e.sp = sp; e.cnt = 0; e.top = 0; e.below = 0;
    e.wtype = 0; e.waddr = 0; e.wdata = 0; e.dly = 0; e.slp = 0;
    case (op)
      "+": begin e.top = (b + a) % 256;       e.sp = (sp + 31) % 32; e.cnt = 1; end
      "-": begin e.top = (b - a + 256) % 256; e.sp = (sp + 31) % 32; e.cnt = 1; end
      "&": begin e.top = b & a;               e.sp = (sp + 31) % 32; e.cnt = 1; end
      "|": begin e.top = b | a;               e.sp = (sp + 31) % 32; e.cnt = 1; end
      "^": begin e.top = b ^ a;               e.sp = (sp + 31) % 32; e.cnt = 1; end
      ">": begin e.top = (a >= 8) ? 0 : b / (1 << a);          e.sp = (sp + 31) % 32; e.cnt = 1; end
      "<": begin e.top = (a >= 8) ? 0 : (b * (1 << a)) % 256;  e.sp = (sp + 31) % 32; e.cnt = 1; end
`ifdef SPELL_MUL_EN
      "*": begin e.top = (b * a) % 256;       e.sp = (sp + 31) % 32; e.cnt = 1; end
`endif
      "2": begin e.top = a; e.sp = (sp + 1) % 32; e.cnt = 1; end
      "x": begin e.top = b; e.below = a; e.cnt = 2; end
      "=": begin e.pc = a; e.sp = (sp + 31) % 32; end
      "@": begin
        if (b != 0) begin e.pc = a; e.sp = (sp + 31) % 32; e.top = b - 1; e.cnt = 1; end
        else e.sp = (sp + 30) % 32;
      end
      "?", "r": begin e.top = mem; e.cnt = 1; end
      "!", "w": begin e.wtype = (op == "!") ? 1 : 2; e.waddr = a; e.wdata = b; e.sp = (sp + 30) % 32; end
      ",": begin e.dly = a; e.sp = (sp + 31) % 32; end
      "z": e.slp = 1;
      default: begin e.top = op; e.sp = (sp + 1) % 32; e.cnt = 1; end
    endcase
    return e;
  endfunction

  // Applies one instruction, waits one clock, compares every defined output.
  task automatic run_op(input int op, input int pc, input int sp, input int a, input int b,
                        input int mem, input bit ooo);
    exp_t e;
    string t;
    exe.opcode = 8'(op); exe.pc = 8'(pc); exe.sp = 5'(sp);
    exe.stack_top = 8'(a); exe.stack_belowtop = 8'(b);
    exe.memory_input = 8'(mem); exe.out_of_order_exec = ooo;
    e = ref_model(op, pc, sp, a, b, mem, ooo);
    @(posedge clk);
    #1;
    t = $sformatf("op%02h", op);
    check_val({t, ".pc"},    int'(exe.next_pc), e.pc);
    check_val({t, ".sp"},    int'(exe.next_sp), e.sp);
    check_val({t, ".cnt"},   int'(exe.stack_write_count), e.cnt);
    if (e.cnt >= 1) check_val({t, ".top"},   int'(exe.set_stack_top), e.top);
    if (e.cnt == 2) check_val({t, ".below"}, int'(exe.set_stack_belowtop), e.below);
    check_val({t, ".wtype"}, int'(exe.memory_write_type), e.wtype);
    if (e.wtype != 0) begin
      check_val({t, ".waddr"}, int'(exe.memory_write_addr), e.waddr);
      check_val({t, ".wdata"}, int'(exe.memory_write_data), e.wdata);
    end
    check_val({t, ".dly"},   int'(exe.delay_amount), e.dly);
    check_val({t, ".sleep"}, int'(exe.sleep), e.slp);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".pc"},    int'(exe.next_pc), 0);
    check_val({tag, ".sp"},    int'(exe.next_sp), 0);
    check_val({tag, ".cnt"},   int'(exe.stack_write_count), 0);
    check_val({tag, ".top"},   int'(exe.set_stack_top), 0);
    check_val({tag, ".below"}, int'(exe.set_stack_belowtop), 0);
    check_val({tag, ".wtype"}, int'(exe.memory_write_type), 0);
    check_val({tag, ".waddr"}, int'(exe.memory_write_addr), 0);
    check_val({tag, ".wdata"}, int'(exe.memory_write_data), 0);
    check_val({tag, ".dly"},   int'(exe.delay_amount), 0);
    check_val({tag, ".sleep"}, int'(exe.sleep), 0);
  endtask

  int ops [18] = '{"+", "-", "&", "|", "^", ">", "<", "2", "x", "=", "@", "?", "r", "!", "w", ",", "z", "*"};

  initial begin
    checks_r = 0;
    failures_r = 0;
    rst_n = 1'b0;
    exe.opcode = 8'd0; exe.pc = 8'd0; exe.sp = 5'd0;
    exe.stack_top = 8'd0; exe.stack_belowtop = 8'd0;
    exe.memory_input = 8'd0; exe.out_of_order_exec = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: sp=2, b=15, a=10, pc=0, memory_input=0x42.
    foreach (ops[i]) run_op(ops[i], 0, 2, 10, 15, 8'h42, 1'b0);
    run_op("+", 0, 2, 10, 15, 8'h42, 1'b0);
    check_val("dir.add_top25", int'(exe.set_stack_top), 25);
    run_op("@", 0, 2, 10, 0, 8'h42, 1'b0);
    check_val("dir.loop0_sp", int'(exe.next_sp), 0);
    check_val("dir.loop0_pc", int'(exe.next_pc), 1);
    run_op("A", 0, 2, 10, 15, 8'h42, 1'b0);
    check_val("dir.lit_top", int'(exe.set_stack_top), 8'h41);
    check_val("dir.lit_sp", int'(exe.next_sp), 3);
    run_op("A", 0, 2, 10, 15, 8'h42, 1'b1);
    check_val("dir.ooo_pc", int'(exe.next_pc), 0);
    run_op("=", 7, 2, 10, 15, 8'h42, 1'b1);
    check_val("dir.ooo_jump", int'(exe.next_pc), 10);
    run_op("+", 255, 0, 1, 2, 0, 1'b0);
    check_val("dir.sp_wrap", int'(exe.next_sp), 31);
    check_val("dir.pc_wrap", int'(exe.next_pc), 0);
    run_op(">", 0, 3, 8, 8'hFF, 0, 1'b0);
    run_op("<", 0, 3, 200, 8'hFF, 0, 1'b0);
    run_op("*", 0, 2, 10, 15, 0, 1'b0);
`ifdef SPELL_MUL_EN
    check_val("dir.mul", int'(exe.set_stack_top), 150);
`else
    check_val("dir.mul_lit", int'(exe.set_stack_top), 8'h2A);
`endif

    // Asynchronous reset mid-run, away from any clock edge.
    run_op("A", 0, 2, 10, 15, 8'h42, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized: mix of known opcodes and arbitrary bytes.
    for (int n = 0; n < 400; n++) begin
      int op;
      if ($urandom_range(0, 3) != 0) op = ops[$urandom_range(0, 17)];
      else op = $urandom_range(0, 255);
      run_op(op, $urandom_range(0, 255), $urandom_range(0, 31),
             ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255),
             ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 255),
             $urandom_range(0, 255), 1'($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule
